sync_mem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for a single-port `sync_mem` instance (DEPTH-bit address, WIDTH-bit data, synchronous write, registered read). It owns the memory's `writeEnable`/`address`/`writeData` inputs, so two independent requesters can share one memory. Each requester gets a valid/ready request handshake and a one-cycle response pulse. One transaction is in flight at a time.

---
 rtl/sync_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sync_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sync_mem_arbiter
// Brief    : Two-port round-robin arbiter and sequencer for one single-port
//            synchronous memory. One transaction is in flight at a time; each
//            requester sees a valid/ready request and a one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module sync_mem_arbiter #(
    parameter int DEPTH        = 4,
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             req0Valid,
    input  logic             req0Write,
    input  logic [DEPTH-1:0] req0Address,
    input  logic [WIDTH-1:0] req0WriteData,
    output logic             req0Ready,
    input  logic             req1Valid,
    input  logic             req1Write,
    input  logic [DEPTH-1:0] req1Address,
    input  logic [WIDTH-1:0] req1WriteData,
    output logic             req1Ready,
    output logic             rsp0Valid,
    output logic [WIDTH-1:0] rsp0Data,
    output logic             rsp1Valid,
    output logic [WIDTH-1:0] rsp1Data,
    output logic             memWriteEnable,
    output logic [DEPTH-1:0] memAddress,
    output logic [WIDTH-1:0] memWriteData,
    input  logic [WIDTH-1:0] memReadData
);

    // Down-counter spans READ_LATENCY WAIT cycles: loaded with LATENCY-1, exits at 0.
    localparam int c_cntWidth = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [c_cntWidth-1:0] c_waitLoad = c_cntWidth'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } stateType;

    stateType              r_state;
    stateType              w_nextState;
    logic                  r_owner;      // 0 = requester 0, 1 = requester 1
    logic                  r_isWrite;
    logic                  r_pointer;    // requester with priority on a tie
    logic [DEPTH-1:0]      r_address;
    logic [WIDTH-1:0]      r_writeData;
    logic [c_cntWidth-1:0] r_waitCount;
    logic [WIDTH-1:0]      r_rsp0Data;
    logic [WIDTH-1:0]      r_rsp1Data;
    logic                  w_grant0;
    logic                  w_grant1;

    assign memAddress   = r_address;
    assign memWriteData = r_writeData;
    assign rsp0Data     = r_rsp0Data;
    assign rsp1Data     = r_rsp1Data;

    // State register; asynchronous clear returns to IDLE mid-transaction.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant, next-state and handshake outputs. Readies are gated by resetN so
    // nothing looks accepted while reset is held.
    always_comb begin
        w_nextState    = r_state;
        w_grant0       = 1'b0;
        w_grant1       = 1'b0;
        req0Ready      = 1'b0;
        req1Ready      = 1'b0;
        rsp0Valid      = 1'b0;
        rsp1Valid      = 1'b0;
        memWriteEnable = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant0  = resetN && req0Valid && (!req1Valid || !r_pointer);
                w_grant1  = resetN && req1Valid && (!req0Valid ||  r_pointer);
                req0Ready = w_grant0;
                req1Ready = w_grant1;
                if (w_grant0 || w_grant1) begin
                    w_nextState = S_ACCESS;
                end
            end
            S_ACCESS: begin
                memWriteEnable = r_isWrite;
                w_nextState    = r_isWrite ? S_RESPOND : S_WAIT;
            end
            S_WAIT: begin
                if (r_waitCount == '0) begin
                    w_nextState = S_RESPOND;
                end
            end
            S_RESPOND: begin
                rsp0Valid   = !r_owner;
                rsp1Valid   =  r_owner;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Transaction latch, latency counter, response data and round-robin pointer.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_owner     <= 1'b0;
            r_isWrite   <= 1'b0;
            r_pointer   <= 1'b0;
            r_address   <= '0;
            r_writeData <= '0;
            r_waitCount <= '0;
            r_rsp0Data  <= '0;
            r_rsp1Data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_owner     <= w_grant1;
                        r_isWrite   <= w_grant1 ? req1Write     : req0Write;
                        r_address   <= w_grant1 ? req1Address   : req0Address;
                        r_writeData <= w_grant1 ? req1WriteData : req0WriteData;
                    end
                end
                S_ACCESS: begin
                    r_waitCount <= c_waitLoad;
                    // A write response carries zero data, set up ahead of RESPOND.
                    if (r_isWrite) begin
                        if (r_owner) begin
                            r_rsp1Data <= '0;
                        end else begin
                            r_rsp0Data <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_waitCount == '0) begin
                        if (r_owner) begin
                            r_rsp1Data <= memReadData;
                        end else begin
                            r_rsp0Data <= memReadData;
                        end
                    end else begin
                        r_waitCount <= r_waitCount - 1'b1;
                    end
                end
                S_RESPOND: begin
                    r_pointer <= ~r_owner;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_mem_arbiter
// Brief    : Directed self-checking bench for sync_mem_arbiter with behavioural
//            memories (latency 1 and latency 3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_mem_arbiter;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   nTests = 0;
    int   nFail  = 0;

    // ---------------- DUT A : READ_LATENCY = 1 ----------------
    logic       aReq0Valid = 0, aReq0Write = 0, aReq1Valid = 0, aReq1Write = 0;
    logic [3:0] aReq0Address = 0, aReq1Address = 0;
    logic [7:0] aReq0WriteData = 0, aReq1WriteData = 0;
    logic       aReq0Ready, aReq1Ready, aRsp0Valid, aRsp1Valid, aMemWe;
    logic [7:0] aRsp0Data, aRsp1Data, aMemWd, aMemRd;
    logic [3:0] aMemAddr;
    logic [7:0] memA [16];

    // ---------------- DUT B : READ_LATENCY = 3 ----------------
    logic       bReq0Valid = 0, bReq0Write = 0;
    logic [3:0] bReq0Address = 0;
    logic [7:0] bReq0WriteData = 0;
    logic       bReq0Ready, bReq1Ready, bRsp0Valid, bRsp1Valid, bMemWe;
    logic [7:0] bRsp0Data, bRsp1Data, bMemWd, bMemRd, bPipe1, bPipe2;
    logic [3:0] bMemAddr;
    logic [7:0] memB [16];
    logic       bIdleValid = 1'b0;
    logic       bIdleWrite = 1'b0;
    logic [3:0] bIdleAddr  = 4'd0;
    logic [7:0] bIdleData  = 8'd0;

    // Monitor state
    int   rsp0CountA = 0;
    int   rsp1CountA = 0;
    logic bothReadySeen = 1'b0;

    always #5 clk = ~clk;

    sync_mem_arbiter #(.DEPTH(4), .WIDTH(8), .READ_LATENCY(1)) dutA (
        .clock(clk), .resetN(resetN),
        .req0Valid(aReq0Valid), .req0Write(aReq0Write), .req0Address(aReq0Address),
        .req0WriteData(aReq0WriteData), .req0Ready(aReq0Ready),
        .req1Valid(aReq1Valid), .req1Write(aReq1Write), .req1Address(aReq1Address),
        .req1WriteData(aReq1WriteData), .req1Ready(aReq1Ready),
        .rsp0Valid(aRsp0Valid), .rsp0Data(aRsp0Data),
        .rsp1Valid(aRsp1Valid), .rsp1Data(aRsp1Data),
        .memWriteEnable(aMemWe), .memAddress(aMemAddr), .memWriteData(aMemWd),
        .memReadData(aMemRd)
    );

    sync_mem_arbiter #(.DEPTH(4), .WIDTH(8), .READ_LATENCY(3)) dutB (
        .clock(clk), .resetN(resetN),
        .req0Valid(bReq0Valid), .req0Write(bReq0Write), .req0Address(bReq0Address),
        .req0WriteData(bReq0WriteData), .req0Ready(bReq0Ready),
        .req1Valid(bIdleValid), .req1Write(bIdleWrite), .req1Address(bIdleAddr),
        .req1WriteData(bIdleData), .req1Ready(bReq1Ready),
        .rsp0Valid(bRsp0Valid), .rsp0Data(bRsp0Data),
        .rsp1Valid(bRsp1Valid), .rsp1Data(bRsp1Data),
        .memWriteEnable(bMemWe), .memAddress(bMemAddr), .memWriteData(bMemWd),
        .memReadData(bMemRd)
    );

    // Memory model A: synchronous write, one registered read stage.
    always @(posedge clk) begin
        if (aMemWe) memA[aMemAddr] <= aMemWd;
        aMemRd <= memA[aMemAddr];
    end

    // Memory model B: synchronous write, three registered read stages.
    always @(posedge clk) begin
        if (bMemWe) memB[bMemAddr] <= bMemWd;
        bPipe1 <= memB[bMemAddr];
        bPipe2 <= bPipe1;
        bMemRd <= bPipe2;
    end

    // Response pulse counters and ready-overlap detector for DUT A.
    always @(negedge clk) begin
        if (aRsp0Valid) rsp0CountA <= rsp0CountA + 1;
        if (aRsp1Valid) rsp1CountA <= rsp1CountA + 1;
        if (aReq0Ready && aReq1Ready) bothReadySeen <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nTests++;
        assert (observed === expected) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        int snap0;
        int snap1;
        int waited;

        // ---------------- Reset with both requesters valid ----------------
        aReq0Valid = 1; aReq1Valid = 1;
        repeat (2) tick();
        chk("rst_memWe",     aMemWe,     0);
        chk("rst_memAddr",   aMemAddr,   0);
        chk("rst_memWd",     aMemWd,     0);
        chk("rst_rsp0Valid", aRsp0Valid, 0);
        chk("rst_rsp1Valid", aRsp1Valid, 0);
        chk("rst_rsp0Data",  aRsp0Data,  0);
        chk("rst_rsp1Data",  aRsp1Data,  0);
        chk("rst_req0Ready", aReq0Ready, 0);
        chk("rst_req1Ready", aReq1Ready, 0);
        chk("rst_B_memAddr", bMemAddr,   0);
        resetN = 1;
        #1;
        chk("rel_req0Ready", aReq0Ready, 1);
        chk("rel_req1Ready", aReq1Ready, 0);
        aReq0Valid = 0; aReq1Valid = 0;
        tick();

        // ---------------- Port 0 write 3=A5 then read ----------------
        snap1 = rsp1CountA;
        aReq0Valid = 1; aReq0Write = 1; aReq0Address = 4'd3; aReq0WriteData = 8'hA5;
        #1;
        chk("wr_ready", aReq0Ready, 1);
        tick();                                   // E0
        aReq0Valid = 0;
        chk("wr_memWe_access", aMemWe, 1);
        chk("wr_memAddr", aMemAddr, 4'd3);
        chk("wr_memWd", aMemWd, 8'hA5);
        chk("wr_rsp0_E0", aRsp0Valid, 0);
        chk("wr_ready_busy", aReq0Ready, 0);
        tick();                                   // E1
        chk("wr_memWe_E1", aMemWe, 0);
        chk("wr_rsp0_E1", aRsp0Valid, 1);
        chk("wr_rsp0Data_zero", aRsp0Data, 0);
        tick();                                   // E2
        chk("wr_rsp0_E2", aRsp0Valid, 0);
        aReq0Valid = 1; aReq0Write = 0; aReq0Address = 4'd3;
        #1;
        chk("rd_ready", aReq0Ready, 1);
        tick();                                   // E0 (E3 of the write)
        aReq0Valid = 0;
        chk("rd_memWe_access", aMemWe, 0);
        chk("rd_memAddr", aMemAddr, 4'd3);
        tick();                                   // E1
        chk("rd_rsp0_E1", aRsp0Valid, 0);
        tick();                                   // E2
        chk("rd_rsp0_E2", aRsp0Valid, 1);
        chk("rd_rsp0Data", aRsp0Data, 8'hA5);
        tick();
        chk("rd_rsp0_E3", aRsp0Valid, 0);
        chk("rd_rsp0Data_held", aRsp0Data, 8'hA5);
        chk("p0_no_rsp1", rsp1CountA - snap1, 0);

        // ---------------- Fairness, both holding read requests ----------------
        resetN = 0; tick(); resetN = 1; #1;
        aReq0Valid = 1; aReq0Write = 0; aReq0Address = 4'd0;
        aReq1Valid = 1; aReq1Write = 0; aReq1Address = 4'd1;
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            tick();
            while (!(aRsp0Valid || aRsp1Valid) && waited < 12) begin
                tick();
                waited++;
            end
            chk($sformatf("fair_grant%0d", i), {30'd0, aRsp1Valid, aRsp0Valid},
                (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        aReq0Valid = 0; aReq1Valid = 0;
        tick();
        chk("fair_no_both_ready", bothReadySeen, 0);

        // ---------------- Ordering: write 5=3C (p0) vs read 5 (p1) ----------------
        resetN = 0; tick(); resetN = 1; #1;
        aReq0Valid = 1; aReq0Write = 1; aReq0Address = 4'd5; aReq0WriteData = 8'h3C;
        aReq1Valid = 1; aReq1Write = 0; aReq1Address = 4'd5;
        #1;
        chk("ord_req0Ready", aReq0Ready, 1);
        chk("ord_req1Ready", aReq1Ready, 0);
        tick();                                   // E0 (p0 accepted)
        aReq0Valid = 0;
        tick();                                   // E1
        chk("ord_rsp0_first", aRsp0Valid, 1);
        chk("ord_rsp1_not_first", aRsp1Valid, 0);
        tick();                                   // E2 idle
        chk("ord_req1Ready_after", aReq1Ready, 1);
        tick();                                   // accept p1
        aReq1Valid = 0;
        tick();                                   // wait
        chk("ord_rsp1_early", aRsp1Valid, 0);
        tick();                                   // respond
        chk("ord_rsp1Valid", aRsp1Valid, 1);
        chk("ord_rsp1Data", aRsp1Data, 8'h3C);
        tick();

        // ---------------- Abort a write in ACCESS ----------------
        aReq0Valid = 1; aReq0Write = 1; aReq0Address = 4'd7; aReq0WriteData = 8'h11;
        tick();
        aReq0Valid = 0;
        repeat (2) tick();
        aReq0Valid = 1; aReq0Write = 1; aReq0Address = 4'd7; aReq0WriteData = 8'hFF;
        tick();                                   // E0, now in ACCESS
        aReq0Valid = 0;
        snap0 = rsp0CountA;
        chk("abort_we_before", aMemWe, 1);
        #3;
        resetN = 0;
        #1;
        chk("abort_we_drop", aMemWe, 0);
        chk("abort_rsp0_now", aRsp0Valid, 0);
        repeat (3) tick();
        resetN = 1;
        tick();
        chk("abort_no_rsp", rsp0CountA - snap0, 0);
        aReq0Valid = 1; aReq0Write = 0; aReq0Address = 4'd7;
        tick();
        aReq0Valid = 0;
        tick();
        tick();
        chk("abort_rd_rsp0", aRsp0Valid, 1);
        chk("abort_rd_data", aRsp0Data, 8'h11);
        tick();

        // ---------------- READ_LATENCY = 3 on DUT B ----------------
        bReq0Valid = 1; bReq0Write = 1; bReq0Address = 4'd2; bReq0WriteData = 8'h77;
        tick();
        bReq0Valid = 0;
        tick();
        chk("lat_wr_rsp", bRsp0Valid, 1);
        tick();
        bReq0Valid = 1; bReq0Write = 0; bReq0Address = 4'd2;
        tick();                                   // E0
        bReq0Valid = 0;
        chk("lat_memAddr", bMemAddr, 4'd2);
        for (int e = 1; e <= 3; e++) begin
            tick();
            chk($sformatf("lat_rsp_E%0d", e), bRsp0Valid, 0);
        end
        tick();                                   // E4
        chk("lat_rsp_E4", bRsp0Valid, 1);
        chk("lat_data_E4", bRsp0Data, 8'h77);
        tick();                                   // E5
        chk("lat_rsp_E5", bRsp0Valid, 0);
        chk("final_no_both_ready", bothReadySeen, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
